// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus ELEC374 datapath (registers, bus priority mux, ALU, Z/C/ports).
// Define DATAPATH_MULDIV_EN to build the signed MUL/DIV opcodes; otherwise they yield zero.
module cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighin,
    input  logic             ZLowin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             OutPort,
    input  logic             Cin,
    input  logic             Yin,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             PCout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHighout,
    input  logic             ZLowout,
    input  logic             MDRout,
    input  logic             InPort,
    input  logic             Cout,
    input  logic             Read,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             IncPC,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] InPortData,
    output logic [WIDTH-1:0] OutPortData,
    output logic [WIDTH-1:0] MARData,
    output logic [WIDTH-1:0] BusMuxOut
);
    logic [15:0] r_in, r_out;
    logic [WIDTH-1:0] r [16];
    logic [WIDTH-1:0] pc, ir, hi, lo, mar, mdr, y, c, out_reg, bus;
    logic [2*WIDTH-1:0] z, c64;
    logic [4:0] s;
    logic [WIDTH-1:0] sra, ror, rol;
    logic unused_ir;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign unused_ir = ^ir[WIDTH-1:19];

    // Lowest-priority source is applied first so higher-priority selects overwrite it.
    always_comb begin
        bus = '0;
        if (Cout) bus = c;
        if (InPort) bus = InPortData;
        if (MDRout) bus = mdr;
        if (ZLowout) bus = z[WIDTH-1:0];
        if (ZHighout) bus = z[2*WIDTH-1:WIDTH];
        if (LOout) bus = lo;
        if (HIout) bus = hi;
        if (PCout) bus = pc;
        for (int i = 15; i >= 0; i--)
            if (r_out[i]) bus = r[i];
    end

    assign s   = bus[4:0];
    assign sra = $signed(y) >>> s;
    assign ror = (y >> s) | (y << (6'd32 - {1'b0, s}));
    assign rol = (y << s) | (y >> (6'd32 - {1'b0, s}));

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] quo, rem;
    assign prod = $signed(y) * $signed(bus);
    assign quo  = $signed(y) / $signed(bus);
    assign rem  = $signed(y) % $signed(bus);
`endif

    always_comb begin
        c64 = '0;
        if (IncPC)
            c64 = {{WIDTH{1'b0}}, bus + 1'b1};
        else
            case (OP)
                5'b00011: c64 = {{WIDTH{1'b0}}, y & bus};
                5'b00100: c64 = {{WIDTH{1'b0}}, y + bus};
                5'b00101: c64 = {{WIDTH{1'b0}}, y - bus};
                5'b00110: c64 = {{WIDTH{1'b0}}, y >> s};
                5'b00111: c64 = {{WIDTH{1'b0}}, sra};
                5'b01000: c64 = {{WIDTH{1'b0}}, y << s};
                5'b01001: c64 = {{WIDTH{1'b0}}, ror};
                5'b01010: c64 = {{WIDTH{1'b0}}, rol};
                5'b01011: c64 = {{WIDTH{1'b0}}, y | bus};
                5'b10001: c64 = {{WIDTH{1'b0}}, -bus};
                5'b10010: c64 = {{WIDTH{1'b0}}, ~bus};
`ifdef DATAPATH_MULDIV_EN
                5'b01111: c64 = prod;
                5'b10000: c64 = bus == '0 ? '0 : {rem, quo};
`endif
                default:  c64 = '0;
            endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            hi      <= '0;
            lo      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            z       <= '0;
            c       <= '0;
            out_reg <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (r_in[i]) r[i] <= bus;
            if (PCin) pc <= bus;
            if (IRin) ir <= bus;
            if (HIin) hi <= bus;
            if (LOin) lo <= bus;
            if (ZHighin) z[2*WIDTH-1:WIDTH] <= c64[2*WIDTH-1:WIDTH];
            if (ZLowin) z[WIDTH-1:0] <= c64[WIDTH-1:0];
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;
            if (OutPort) out_reg <= bus;
            if (Cin) c <= {{(WIDTH-19){ir[18]}}, ir[18:0]};
            if (Yin) y <= bus;
        end
    end

    assign OutPortData = out_reg;
    assign MARData     = mar;
    assign BusMuxOut   = bus;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: vector table plus hand sequences for cpu_datapath, expected values queued and popped on compare.
module tb_cpu_datapath;
`ifdef DATAPATH_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int PCI = 16, IRI = 17, HII = 18, LOI = 19, ZHI = 20, ZLI = 21, MARI = 22, MDRI = 23, OUTI = 24, CI = 25, YI = 26;
    localparam int PCO = 16, HIO = 17, LOO = 18, ZHO = 19, ZLO = 20, MDRO = 21, INO = 22, CO = 23;
    localparam logic [31:0] INV = 32'hCAFE0001;

    typedef struct {
        string       name;
        logic [26:0] en;
        logic [23:0] src;
        logic [23:0] obs;
        logic [31:0] want;
        logic [4:0]  op;
        logic        inc;
        logic        rd;
        logic [31:0] md;
        int          kind;
    } vec_t;
    typedef struct {
        string       name;
        logic [31:0] want;
    } exp_t;

    logic        Clock, Clear, rd, inc;
    logic [26:0] en;
    logic [23:0] src;
    logic [31:0] md, inport;
    logic [4:0]  op;
    logic [31:0] out_data, mar_data, bus_out;
    int total = 0, bad = 0;
    exp_t sb[$];
    vec_t vt[$];

    cpu_datapath dut (
        .Clock(Clock), .Clear(Clear),
        .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]), .R4in(en[4]), .R5in(en[5]),
        .R6in(en[6]), .R7in(en[7]), .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
        .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
        .PCin(en[PCI]), .IRin(en[IRI]), .HIin(en[HII]), .LOin(en[LOI]), .ZHighin(en[ZHI]),
        .ZLowin(en[ZLI]), .MARin(en[MARI]), .MDRin(en[MDRI]), .OutPort(en[OUTI]), .Cin(en[CI]), .Yin(en[YI]),
        .R0out(src[0]), .R1out(src[1]), .R2out(src[2]), .R3out(src[3]), .R4out(src[4]), .R5out(src[5]),
        .R6out(src[6]), .R7out(src[7]), .R8out(src[8]), .R9out(src[9]), .R10out(src[10]), .R11out(src[11]),
        .R12out(src[12]), .R13out(src[13]), .R14out(src[14]), .R15out(src[15]),
        .PCout(src[PCO]), .HIout(src[HIO]), .LOout(src[LOO]), .ZHighout(src[ZHO]), .ZLowout(src[ZLO]),
        .MDRout(src[MDRO]), .InPort(src[INO]), .Cout(src[CO]),
        .Read(rd), .Mdatain(md), .IncPC(inc), .OP(op), .InPortData(inport),
        .OutPortData(out_data), .MARData(mar_data), .BusMuxOut(bus_out)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic logic [26:0] ie(int i);
        return 27'd1 << i;
    endfunction
    function automatic logic [23:0] oe(int i);
        return 24'd1 << i;
    endfunction
    function automatic vec_t mk(string n, logic [26:0] e, logic [23:0] s, logic [23:0] o, logic [31:0] w,
                                logic [4:0] p = 5'd0, logic i = 1'b0, logic r = 1'b0, logic [31:0] m = 32'd0, int k = 0);
        return '{name: n, en: e, src: s, obs: o, want: w, op: p, inc: i, rd: r, md: m, kind: k};
    endfunction
    function automatic vec_t mdr(logic [31:0] v);
        return mk("mdr_load", ie(MDRI), 24'd0, oe(MDRO), v, 5'd0, 1'b0, 1'b1, v);
    endfunction

    task automatic idle(input logic [23:0] s);
        en = '0; src = s; rd = 1'b0; inc = 1'b0; op = '0; md = '0;
    endtask

    task automatic compare(input logic [31:0] act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
            return;
        end
        e = sb.pop_front();
        if (act !== e.want) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, act, e.want);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] w, input logic [31:0] act);
        sb.push_back('{name: n, want: w});
        compare(act);
    endtask

    task automatic run(input vec_t v);
        @(negedge Clock);
        en = v.en; src = v.src; rd = v.rd; md = v.md; inc = v.inc; op = v.op;
        sb.push_back('{name: v.name, want: v.want});
        @(posedge Clock);
        #1;
        idle(v.kind == 0 ? v.obs : 24'd0);
        #1;
        compare(v.kind == 0 ? bus_out : v.kind == 1 ? mar_data : out_data);
    endtask

    initial begin
        inport = INV;
        idle(oe(PCO));
        Clear = 1'b0;
        #1;
        chk("reset_bus", 32'h0, bus_out);
        chk("reset_mar", 32'h0, mar_data);
        chk("reset_out", 32'h0, out_data);
        #2 Clear = 1'b1;

        vt.push_back(mdr(32'h12));
        vt.push_back(mk("r0_load", ie(0), oe(MDRO), oe(0), 32'h12));
        vt.push_back(mdr(32'h14));
        vt.push_back(mk("r4_load", ie(4), oe(MDRO), oe(4), 32'h14));
        vt.push_back(mdr(32'h18));
        vt.push_back(mk("r5_load", ie(5), oe(MDRO), oe(5), 32'h18));
        vt.push_back(mk("fetch_mar", ie(MARI) | ie(ZLI), oe(PCO), 24'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 1));
        vt.push_back(mk("fetch_zl", 27'd0, 24'd0, oe(ZLO), 32'h1));
        vt.push_back(mk("fetch_pc", ie(PCI) | ie(MDRI), oe(ZLO), oe(PCO), 32'h1, 5'd0, 1'b0, 1'b1, 32'h18228000));
        vt.push_back(mk("fetch_mdr", 27'd0, 24'd0, oe(MDRO), 32'h18228000));
        vt.push_back(mk("fetch_ir", ie(IRI), oe(MDRO), oe(MDRO), 32'h18228000));
        vt.push_back(mk("c_pos", ie(CI), 24'd0, oe(CO), 32'h00028000));
        vt.push_back(mk("y_r4", ie(YI), oe(4), oe(4), 32'h14));
        vt.push_back(mk("add", ie(ZLI), oe(5), oe(ZLO), 32'h2C, 5'b00100));
        vt.push_back(mk("r0_add", ie(0), oe(ZLO), oe(0), 32'h2C));
        vt.push_back(mdr(32'h1));
        vt.push_back(mk("r1_load", ie(1), oe(MDRO), oe(1), 32'h1));
        vt.push_back(mdr(32'h80000001));
        vt.push_back(mk("y_load", ie(YI), oe(MDRO), oe(MDRO), 32'h80000001));
        vt.push_back(mk("shra", ie(ZLI), oe(1), oe(ZLO), 32'hC0000000, 5'b00111));
        vt.push_back(mk("shr", ie(ZLI), oe(1), oe(ZLO), 32'h40000000, 5'b00110));
        vt.push_back(mk("rol", ie(ZLI), oe(1), oe(ZLO), 32'h00000003, 5'b01010));
        vt.push_back(mk("ror", ie(ZLI), oe(1), oe(ZLO), 32'hC0000000, 5'b01001));
        vt.push_back(mk("shl", ie(ZLI), oe(1), oe(ZLO), 32'h00000002, 5'b01000));
        vt.push_back(mk("and", ie(ZLI), oe(1), oe(ZLO), 32'h00000001, 5'b00011));
        vt.push_back(mk("or", ie(ZLI), oe(1), oe(ZLO), 32'h80000001, 5'b01011));
        vt.push_back(mk("sub", ie(ZLI), oe(1), oe(ZLO), 32'h80000000, 5'b00101));
        vt.push_back(mk("neg", ie(ZLI), oe(1), oe(ZLO), 32'hFFFFFFFF, 5'b10001));
        vt.push_back(mk("not", ie(ZLI), oe(1), oe(ZLO), 32'hFFFFFFFE, 5'b10010));
        vt.push_back(mk("add_wrap", ie(ZLI), oe(1), oe(ZLO), 32'h80000002, 5'b00100));
        vt.push_back(mk("op_00000", ie(ZLI), oe(1), oe(ZLO), 32'h0, 5'b00000));
        vt.push_back(mk("op_11111", ie(ZLI), oe(1), oe(ZLO), 32'h0, 5'b11111));
        vt.push_back(mdr(32'hFFFFFFFE));
        vt.push_back(mk("y_m2", ie(YI), oe(MDRO), oe(MDRO), 32'hFFFFFFFE));
        vt.push_back(mdr(32'h3));
        vt.push_back(mk("r2_3", ie(2), oe(MDRO), oe(2), 32'h3));
        vt.push_back(mk("mul_hi", ie(ZHI) | ie(ZLI), oe(2), oe(ZHO), MD ? 32'hFFFFFFFF : 32'h0, 5'b01111));
        vt.push_back(mk("mul_lo", 27'd0, 24'd0, oe(ZLO), MD ? 32'hFFFFFFFA : 32'h0));
        vt.push_back(mk("zh_zeroext", ie(ZHI) | ie(ZLI), oe(2), oe(ZHO), 32'h0, 5'b00011));
        vt.push_back(mdr(32'h2));
        vt.push_back(mk("r2_2", ie(2), oe(MDRO), oe(2), 32'h2));
        vt.push_back(mdr(32'h7));
        vt.push_back(mk("y_7", ie(YI), oe(MDRO), oe(MDRO), 32'h7));
        vt.push_back(mk("div_rem", ie(ZHI) | ie(ZLI), oe(2), oe(ZHO), MD ? 32'h1 : 32'h0, 5'b10000));
        vt.push_back(mk("div_quo", 27'd0, 24'd0, oe(ZLO), MD ? 32'h3 : 32'h0));
        vt.push_back(mdr(32'hFFFFFFF9));
        vt.push_back(mk("y_m7", ie(YI), oe(MDRO), oe(MDRO), 32'hFFFFFFF9));
        vt.push_back(mk("sdiv_rem", ie(ZHI) | ie(ZLI), oe(2), oe(ZHO), MD ? 32'hFFFFFFFF : 32'h0, 5'b10000));
        vt.push_back(mk("sdiv_quo", 27'd0, 24'd0, oe(ZLO), MD ? 32'hFFFFFFFD : 32'h0));
        vt.push_back(mk("div0_hi", ie(ZHI) | ie(ZLI), 24'd0, oe(ZHO), 32'h0, 5'b10000));
        vt.push_back(mk("div0_lo", 27'd0, 24'd0, oe(ZLO), 32'h0));
        vt.push_back(mk("hi_load", ie(HII), oe(2), oe(HIO), 32'h2));
        vt.push_back(mk("lo_load", ie(LOI), oe(1), oe(LOO), 32'h1));
        vt.push_back(mk("in_multi_r8", ie(7) | ie(8) | ie(9), oe(INO), oe(8), INV));
        vt.push_back(mk("in_multi_r7", 27'd0, 24'd0, oe(7), INV));
        vt.push_back(mk("in_multi_r9", 27'd0, 24'd0, oe(9), INV));
        vt.push_back(mk("r15_load", ie(15), oe(INO), oe(15), INV));
        vt.push_back(mk("outport", ie(OUTI), oe(9), 24'd0, INV, 5'd0, 1'b0, 1'b0, 32'h0, 2));
        vt.push_back(mk("mar_load", ie(MARI), oe(2), 24'd0, 32'h2, 5'd0, 1'b0, 1'b0, 32'h0, 1));
        vt.push_back(mdr(32'h0007FFFF));
        vt.push_back(mk("ir_neg", ie(IRI), oe(MDRO), oe(MDRO), 32'h0007FFFF));
        vt.push_back(mk("c_all_ones", ie(CI), 24'd0, oe(CO), 32'hFFFFFFFF));
        vt.push_back(mdr(32'h00040000));
        vt.push_back(mk("ir_sign", ie(IRI), oe(MDRO), oe(MDRO), 32'h00040000));
        vt.push_back(mk("c_sign", ie(CI), 24'd0, oe(CO), 32'hFFFC0000));
        vt.push_back(mk("pc_hold", 27'd0, 24'd0, oe(PCO), 32'h1));
        vt.push_back(mk("zl_set", ie(ZLI), oe(1), oe(ZLO), 32'h2, 5'd0, 1'b1));
        foreach (vt[k]) run(vt[k]);

        @(negedge Clock);
        idle(oe(0) | oe(4));
        #1 chk("prio_r0_r4", 32'h2C, bus_out);
        src = oe(PCO) | oe(CO);
        #1 chk("prio_pc_c", 32'h1, bus_out);
        src = oe(15) | oe(PCO);
        #1 chk("prio_r15_pc", INV, bus_out);
        src = oe(ZHO) | oe(ZLO) | oe(MDRO) | oe(INO) | oe(CO);
        #1 chk("prio_zh", 32'h0, bus_out);
        src = '0;
        #1 chk("bus_idle", 32'h0, bus_out);

        @(negedge Clock);
        idle(oe(ZLO));
        en = ie(ZLI);
        inc = 1'b1;
        #1 chk("rw_before_edge", 32'h2, bus_out);
        @(posedge Clock);
        #1 idle(oe(ZLO));
        #1 chk("rw_after_edge", 32'h3, bus_out);

        @(negedge Clock);
        #2 idle(oe(0));
        Clear = 1'b0;
        #1 chk("clr_r0", 32'h0, bus_out);
        chk("clr_mar", 32'h0, mar_data);
        chk("clr_out", 32'h0, out_data);
        src = oe(15);
        #1 chk("clr_r15", 32'h0, bus_out);
        src = oe(CO);
        #1 chk("clr_c", 32'h0, bus_out);
        @(negedge Clock);
        en = ie(MDRI); rd = 1'b1; md = 32'h77;
        @(posedge Clock);
        #1 idle(oe(MDRO));
        #1 chk("clr_holds_mdr", 32'h0, bus_out);
        @(negedge Clock);
        Clear = 1'b1;
        run(mdr(32'h55));
        run(mk("resume_r0", ie(0), oe(MDRO), oe(0), 32'h55));
        run(mk("resume_pc", 27'd0, 24'd0, oe(PCO), 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath for the ELEC374 processor: sixteen general registers R0–R15, PC, IR, HI, LO, MAR, MDR, Y, a 64-bit Z result register, a C immediate register and in/out ports.
- All registers share one 32-bit bus. An ALU combines Y (operand A) with the bus (operand B).
- An external control unit or testbench drives every control strobe. This block makes no sequencing decisions.

Parameters:
- WIDTH, 32, data/bus width. Only 32 is supported.

Ports:
- Clock  in  1  sole clock; all registers update on the rising edge.
- Clear  in  1  asynchronous, active-low reset.
- R0in..R15in  in  1 each  load Rn from the bus.
- PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Cin, Yin  in  1 each  register load enables, in that positional order. OutPort loads the out-port register.
- R0out..R15out  in  1 each  drive Rn onto the bus.
- PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout  in  1 each  bus source selects. InPort selects InPortData.
- Read  in  1  MDR input mux: 1 selects Mdatain, 0 selects the bus.
- Mdatain  in  32  memory read data.
- IncPC  in  1  forces the ALU to bus+1.
- OP  in  5  ALU opcode.
- InPortData  in  32  external input-port value.
- OutPortData  out  32  out-port register.
- MARData  out  32  MAR contents.
- BusMuxOut  out  32  current bus value, for observation.
- Positional order: ports appear in the order listed above. The three extra ports come last.

Behaviour:
- Reset (Clear=0, asynchronous): every register clears to 0. This includes R0–R15, PC, IR, HI, LO, MAR, MDR, Y, Z, C and the out-port register.
- Register loads:
  - A register loads on the rising Clock edge when its enable is 1; otherwise it holds.
  - Several enables may be active together, and all enabled registers load.
  - R0 is an ordinary writable register.
- MDR: loads Mdatain when Read=1, otherwise the bus.
- C register: loads the sign-extended IR[18:0] when Cin=1.
- Bus (combinational):
  - Source is chosen by a priority encoder over the out selects. Priority order: R0out..R15out, PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout, with R0out highest.
  - With no select active, the bus is 0.
- ALU (combinational): A=Y, B=bus, 64-bit result C64. ZHigh loads C64[63:32]; ZLow loads C64[31:0].
- IncPC=1 overrides OP: C64={32'h0, B+1}.
- Opcodes (32-bit results are zero-extended to 64 bits):
  - 00011 AND
  - 00100 ADD (A+B, carry discarded)
  - 00101 SUB (A−B)
  - 00110 SHR (logical right by B[4:0])
  - 00111 SHRA (arithmetic right by B[4:0])
  - 01000 SHL (by B[4:0])
  - 01001 ROR (by B[4:0])
  - 01010 ROL (by B[4:0])
  - 01011 OR
  - 10001 NEG (−B)
  - 10010 NOT (~B)
  - 01111 MUL: signed A×B, 64-bit product.
  - 10000 DIV: signed A/B. C64[31:0]=quotient, C64[63:32]=remainder. B=0 gives C64=0.
  - Any other code gives C64=0.
- Latency: a register-to-register transfer takes one cycle. An ALU op takes three cycles: Y load, Z load, Z-to-destination.
- Simultaneous read and write of the same register: the register loads the new bus value at the edge, and the bus shows the old value until then.
- Reset mid-sequence: all state clears immediately. Operation resumes once Clear returns to 1.

Optional Feature:
- DATAPATH_MULDIV_EN defined: MUL and DIV are implemented as specified above.
- DATAPATH_MULDIV_EN undefined: opcodes 01111 and 10000 produce C64=0, and no multiplier or divider is synthesized.

Test Plan:
1. Load three registers through MDR: Mdatain=0x12 with Read+MDRin, then MDRout+R0in gives R0=0x12. Repeat to get R4=0x14 and R5=0x18.
2. Fetch: PC=0. Assert PCout+MARin+IncPC+ZLowin, which gives MAR=0 and ZLow=1. Then ZLowout+PCin, plus Read+MDRin with Mdatain=0x18228000, gives PC=1 and MDR=0x18228000. Then MDRout+IRin gives IR=0x18228000.
3. ADD: R4out+Yin gives Y=0x14. Then R5out, OP=00100, ZLowin gives ZLow=0x2C. Then ZLowout+R0in gives R0=0x2C.
4. MUL with DATAPATH_MULDIV_EN defined: Y=0xFFFFFFFE (−2), bus=3 gives Z=0xFFFFFFFF_FFFFFFFA. DIV with Y=7, bus=2 gives ZHigh=1, ZLow=3. DIV with bus=0 gives Z=0.
5. Shifts: Y=0x80000001, bus=1. SHRA gives 0xC0000000, SHR gives 0x40000000, ROL gives 0x00000003.
6. Drive Clear=0 after loading several registers. All registers and outputs read 0 immediately, before any clock edge. With no out select active, BusMuxOut=0.
